// File: rtl/mem_stage_mc_pkg.sv
// Shared definitions for the multi-cycle memory stage: default word width,
// access size encodings and FSM state encoding.
package mem_stage_mc_pkg;

    localparam int DEF_WORD_LEN = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stage_mc_bank.sv
// Data memory bank: DEPTH x WORD_LEN words, per-byte write enables,
// asynchronous read and synchronous active-low clear of every word.
module mem_stage_mc_bank #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 64,
    parameter int BYTES    = WORD_LEN / 8,
    parameter int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IW-1:0]       addr,
    input  logic [BYTES-1:0]    be,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] rdata
);

    logic [WORD_LEN-1:0] mem_r [DEPTH];

    // Word storage: full clear on reset, otherwise byte-lane writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_LEN{1'b0}};
            end
        end else begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: wait-state FSM with upstream stall, byte/half/word
// accesses with optional sign extension, and suppression of bad addresses.
module mem_stage_mc
    import mem_stage_mc_pkg::*;
#(
    parameter int WORD_LEN    = DEF_WORD_LEN,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [WORD_LEN-1:0] alu_res,
    input  logic [WORD_LEN-1:0] st_value,
    output logic [WORD_LEN-1:0] mem_out,
    output logic                stall,
    output logic                done,
    output logic                misalign_err,
    output logic                range_err
);

    localparam int         BYTES     = WORD_LEN / 8;
    localparam int         LB        = $clog2(BYTES);
    localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e              state_r;
    logic [3:0]          cnt_r;
    logic                ld_r;
    logic [1:0]          size_r;
    logic                sign_r;
    logic [WORD_LEN-1:0] addr_r;
    logic [WORD_LEN-1:0] data_r;
    logic [WORD_LEN-1:0] mem_out_r;
    logic                done_r;
    logic                misalign_r;
    logic                range_r;

    logic                req_s;
    logic                fire_s;
    logic                wr_s;
    logic                op_load_s;
    logic                op_sign_s;
    logic [1:0]          op_size_s;
    logic [WORD_LEN-1:0] op_addr_s;
    logic [WORD_LEN-1:0] op_data_s;
    logic [WORD_LEN-1:0] offset_s;
    logic [WORD_LEN-1:0] index_s;
    logic [LB-1:0]       lane_s;
    logic [LB-1:0]       size_mask_s;
    logic                size_ok_s;
    int                  nbytes_s;
    logic                range_err_s;
    logic                misalign_err_s;
    logic [BYTES-1:0]    be_s;
    logic [WORD_LEN-1:0] wdata_s;
    logic [WORD_LEN-1:0] rdata_s;
    logic [WORD_LEN-1:0] shifted_s;
    logic                sbit_s;
    logic [WORD_LEN-1:0] load_val_s;

    assign req_s  = mem_r_en ^ mem_w_en;
    assign fire_s = ((state_r == ST_IDLE) && req_s && (WAIT_STATES == 0)) ||
                    ((state_r == ST_BUSY) && (cnt_r <= 4'd1));
    assign wr_s   = fire_s && !op_load_s && !range_err_s && !misalign_err_s;
    // Reset also drops the freeze request so upstream is released immediately.
    assign stall  = rst && (((state_r == ST_IDLE) && req_s) || (state_r == ST_BUSY));

    // Operand source: live inputs while IDLE, latched request afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_load_s = mem_r_en;
            op_size_s = size;
            op_sign_s = sign_ext;
            op_addr_s = alu_res;
            op_data_s = st_value;
        end else begin
            op_load_s = ld_r;
            op_size_s = size_r;
            op_sign_s = sign_r;
            op_addr_s = addr_r;
            op_data_s = data_r;
        end
    end

    // Address decode, error detection, store lane placement and load extension.
    always_comb begin
        offset_s       = op_addr_s - WORD_LEN'(BASE_ADDR);
        index_s        = offset_s >> LB;
        lane_s         = offset_s[LB-1:0];
        size_ok_s      = (int'(op_size_s) <= LB);
        nbytes_s       = size_ok_s ? int'(32'd1 << op_size_s) : BYTES;
        size_mask_s    = LB'(nbytes_s - 1);
        range_err_s    = (op_addr_s < WORD_LEN'(BASE_ADDR)) || (index_s >= WORD_LEN'(DEPTH));
        misalign_err_s = !size_ok_s || ((lane_s & size_mask_s) != {LB{1'b0}});
        wdata_s        = op_data_s << {lane_s, 3'b000};
        shifted_s      = rdata_s >> {lane_s, 3'b000};
        be_s           = {BYTES{1'b0}};
        load_val_s     = {WORD_LEN{1'b0}};
        case (op_size_s)
            SIZE_B:  sbit_s = shifted_s[7];
            SIZE_H:  sbit_s = shifted_s[15];
            default: sbit_s = shifted_s[WORD_LEN-1];
        endcase
        for (int b = 0; b < BYTES; b++) begin
            be_s[b] = (b >= int'(lane_s)) && (b < int'(lane_s) + nbytes_s);
            if (b < nbytes_s) begin
                load_val_s[b*8 +: 8] = shifted_s[b*8 +: 8];
            end else if (op_sign_s && sbit_s) begin
                load_val_s[b*8 +: 8] = 8'hFF;
            end else begin
                load_val_s[b*8 +: 8] = 8'h00;
            end
        end
    end

    mem_stage_mc_bank #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (DEPTH)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .addr  (index_s[IW-1:0]),
        .be    (wr_s ? be_s : {BYTES{1'b0}}),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // Access FSM, request latch and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            ld_r       <= 1'b0;
            size_r     <= 2'd0;
            sign_r     <= 1'b0;
            addr_r     <= {WORD_LEN{1'b0}};
            data_r     <= {WORD_LEN{1'b0}};
            mem_out_r  <= {WORD_LEN{1'b0}};
            done_r     <= 1'b0;
            misalign_r <= 1'b0;
            range_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        ld_r   <= mem_r_en;
                        size_r <= size;
                        sign_r <= sign_ext;
                        addr_r <= alu_res;
                        data_r <= st_value;
                        if (WAIT_STATES == 0) begin
                            state_r <= ST_DONE;
                            cnt_r   <= 4'd0;
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= WAIT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_DONE;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase

            done_r <= fire_s;
            if (fire_s) begin
                misalign_r <= misalign_err_s;
                range_r    <= range_err_s;
                if (range_err_s || misalign_err_s) begin
                    mem_out_r <= {WORD_LEN{1'b0}};
                end else if (op_load_s) begin
                    mem_out_r <= load_val_s;
                end
            end
        end
    end

    assign mem_out      = mem_out_r;
    assign done         = done_r;
    assign misalign_err = misalign_r;
    assign range_err    = range_r;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Self-checking bench for mem_stage_mc: directed scenarios plus randomized
// accesses checked against a byte-addressed reference memory.
module tb_mem_stage_mc;

    localparam int DEPTH = 64;
    localparam int BASE  = 1024;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en, w_en, sign_ext;
    logic [1:0]  size;
    logic [31:0] alu_res, st_value;
    logic [31:0] mem_out;
    logic        stall, done, mis, rng;

    logic        r1_en, w1_en, sx1;
    logic [1:0]  size1;
    logic [31:0] a1, d1;
    logic [31:0] mem_out1;
    logic        stall1, done1, mis1, rng1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  mbytes [DEPTH*4];
    logic [31:0] model_out;

    always #5 clk = ~clk;

    mem_stage_mc #(.WORD_LEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .size(size),
        .sign_ext(sign_ext), .alu_res(alu_res), .st_value(st_value), .mem_out(mem_out),
        .stall(stall), .done(done), .misalign_err(mis), .range_err(rng));

    mem_stage_mc #(.WORD_LEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r1_en), .mem_w_en(w1_en), .size(size1),
        .sign_ext(sx1), .alu_res(a1), .st_value(d1), .mem_out(mem_out1),
        .stall(stall1), .done(done1), .misalign_err(mis1), .range_err(rng1));

    task automatic model_reset();
        for (int i = 0; i < DEPTH*4; i++) mbytes[i] = 8'h00;
        model_out = 32'h0;
    endtask

    // Reference behaviour: byte-addressed little-endian memory.
    task automatic model_access(input logic wr, input logic [1:0] sz, input logic sx,
                                input logic [31:0] addr, input logic [31:0] data,
                                output logic [31:0] e_out, output logic e_mis, output logic e_rng);
        int          n;
        logic [31:0] off, v;
        n     = 1 << sz;
        off   = addr - BASE;
        e_rng = (addr < BASE) || ((off / 4) >= DEPTH);
        e_mis = (off % n) != 0;
        if (e_rng || e_mis) begin
            model_out = 32'h0;
        end else if (wr) begin
            for (int k = 0; k < n; k++) mbytes[off + k] = data[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(mbytes[off + k]) << (8*k));
            if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            model_out = v;
        end
        e_out = model_out;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                             input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] o_out, output logic o_mis, output logic o_rng,
                             output int o_cyc, output int o_stalls, output logic o_done_after);
        logic got;
        @(posedge clk); #1;
        r_en = rd; w_en = wr; size = sz; sign_ext = sx; alu_res = addr; st_value = data;
        o_cyc = 0; o_stalls = 0; got = 1'b0;
        o_out = 32'hx; o_mis = 1'bx; o_rng = 1'bx;
        while (!got && o_cyc < 40) begin
            @(negedge clk);
            o_cyc++;
            if (stall) o_stalls++;
            if (done) begin
                got = 1'b1; o_out = mem_out; o_mis = mis; o_rng = rng;
            end
        end
        if (!got) o_cyc = -1;
        @(posedge clk); #1;
        r_en = 1'b0; w_en = 1'b0;
        @(negedge clk);
        o_done_after = done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++; if (mem_out !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_out: got %h expected 0", mem_out); end
        tests_run++; if (stall !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_ctrl: stall=%b done=%b expected 0 0", stall, done); end
        tests_run++; if (mis !== 1'b0 || rng !== 1'b0) begin tests_failed++; $display("FAIL reset_err: mis=%b rng=%b expected 0 0", mis, rng); end
    endtask

    task automatic test_word();
        logic [31:0] o, e; logic om, orr, em, er, da; int cyc, st;
        for (int op = 0; op < 2; op++) begin
            do_access(op == 1, op == 0, 2'd2, 1'b0, 32'd1032, 32'hDEAD_BEEF, o, om, orr, cyc, st, da);
            model_access(op == 0, 2'd2, 1'b0, 32'd1032, 32'hDEAD_BEEF, e, em, er);
            tests_run++; if (cyc !== WS + 2) begin tests_failed++; $display("FAIL word_latency: got %0d expected %0d", cyc, WS + 2); end
            tests_run++; if (st !== WS + 1) begin tests_failed++; $display("FAIL word_stall: got %0d expected %0d", st, WS + 1); end
            tests_run++; if (da !== 1'b0) begin tests_failed++; $display("FAIL word_done_pulse: done after=%b expected 0", da); end
        end
        tests_run++; if (o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL word_load: got %h expected deadbeef", o); end
    endtask

    task automatic test_byte();
        logic [31:0] o, e; logic om, orr, em, er, da; int cyc, st;
        do_access(1'b0, 1'b1, 2'd0, 1'b0, 32'd1025, 32'h0000_0080, o, om, orr, cyc, st, da);
        model_access(1'b1, 2'd0, 1'b0, 32'd1025, 32'h0000_0080, e, em, er);
        do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'd1024, 32'h0, o, om, orr, cyc, st, da);
        tests_run++; if (o !== 32'h0000_8000) begin tests_failed++; $display("FAIL byte_word_rd: got %h expected 00008000", o); end
        do_access(1'b1, 1'b0, 2'd0, 1'b1, 32'd1025, 32'h0, o, om, orr, cyc, st, da);
        tests_run++; if (o !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL byte_signed: got %h expected ffffff80", o); end
        do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'd1025, 32'h0, o, om, orr, cyc, st, da);
        tests_run++; if (o !== 32'h0000_0080) begin tests_failed++; $display("FAIL byte_unsigned: got %h expected 00000080", o); end
        model_access(1'b0, 2'd0, 1'b0, 32'd1025, 32'h0, e, em, er);
    endtask

    task automatic test_misalign();
        logic [31:0] o, e; logic om, orr, em, er, da; int cyc, st;
        do_access(1'b1, 1'b0, 2'd1, 1'b0, 32'd1027, 32'h0, o, om, orr, cyc, st, da);
        model_access(1'b0, 2'd1, 1'b0, 32'd1027, 32'h0, e, em, er);
        tests_run++; if (om !== 1'b1 || orr !== 1'b0) begin tests_failed++; $display("FAIL misalign_flag: mis=%b rng=%b expected 1 0", om, orr); end
        tests_run++; if (o !== 32'h0) begin tests_failed++; $display("FAIL misalign_out: got %h expected 0", o); end
        tests_run++; if (cyc !== WS + 2) begin tests_failed++; $display("FAIL misalign_latency: got %0d expected %0d", cyc, WS + 2); end
        do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'd1024, 32'h0, o, om, orr, cyc, st, da);
        model_access(1'b0, 2'd2, 1'b0, 32'd1024, 32'h0, e, em, er);
        tests_run++; if (o !== e) begin tests_failed++; $display("FAIL misalign_mem: got %h expected %h", o, e); end
    endtask

    task automatic test_full_readback();
        logic [31:0] o, e; logic om, orr, em, er, da; int cyc, st;
        for (int i = 0; i < DEPTH; i++) begin
            do_access(1'b1, 1'b0, 2'd2, 1'b0, BASE + 4*i, 32'h0, o, om, orr, cyc, st, da);
            model_access(1'b0, 2'd2, 1'b0, BASE + 4*i, 32'h0, e, em, er);
            tests_run++; if (o !== e) begin tests_failed++; $display("FAIL readback[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_range();
        logic [31:0] o, e, addrs[2]; logic om, orr, em, er, da; int cyc, st;
        addrs[0] = 32'd1020;
        addrs[1] = BASE + 4*DEPTH;
        for (int i = 0; i < 2; i++) begin
            do_access(1'b0, 1'b1, 2'd2, 1'b0, addrs[i], 32'hCAFE_F00D, o, om, orr, cyc, st, da);
            model_access(1'b1, 2'd2, 1'b0, addrs[i], 32'hCAFE_F00D, e, em, er);
            tests_run++; if (orr !== 1'b1 || om !== 1'b0) begin tests_failed++; $display("FAIL range_flag[%0d]: rng=%b mis=%b expected 1 0", i, orr, om); end
            tests_run++; if (cyc !== WS + 2) begin tests_failed++; $display("FAIL range_latency[%0d]: got %0d expected %0d", i, cyc, WS + 2); end
        end
        test_full_readback();
    endtask

    task automatic test_both_enables();
        int sc, dc;
        sc = 0; dc = 0;
        @(posedge clk); #1;
        r_en = 1'b1; w_en = 1'b1; size = 2'd2; alu_res = 32'd1024; st_value = 32'h1111_2222;
        repeat (6) begin
            @(negedge clk);
            if (stall) sc++;
            if (done) dc++;
        end
        @(posedge clk); #1;
        r_en = 1'b0; w_en = 1'b0;
        tests_run++; if (sc !== 0 || dc !== 0) begin tests_failed++; $display("FAIL both_en: stall cycles=%0d done cycles=%0d expected 0 0", sc, dc); end
        tests_run++; if (mem_out !== model_out) begin tests_failed++; $display("FAIL both_en_out: got %h expected %h", mem_out, model_out); end
    endtask

    task automatic test_wait0();
        int cyc, st; logic got;
        for (int op = 0; op < 2; op++) begin
            @(posedge clk); #1;
            r1_en = (op == 1); w1_en = (op == 0); size1 = 2'd2; sx1 = 1'b0; a1 = 32'd1028; d1 = 32'hA5A5_5A5A;
            cyc = 0; st = 0; got = 1'b0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (stall1) st++;
                if (done1) got = 1'b1;
            end
            @(posedge clk); #1;
            r1_en = 1'b0; w1_en = 1'b0;
            tests_run++; if (!got || cyc !== 2) begin tests_failed++; $display("FAIL ws0_latency[%0d]: got %0d expected 2", op, cyc); end
            tests_run++; if (st !== 1) begin tests_failed++; $display("FAIL ws0_stall[%0d]: got %0d expected 1", op, st); end
        end
        tests_run++; if (mem_out1 !== 32'hA5A5_5A5A) begin tests_failed++; $display("FAIL ws0_load: got %h expected a5a55a5a", mem_out1); end
    endtask

    task automatic test_random();
        logic [31:0] o, e, addr, data; logic om, orr, em, er, da, rd, sx; logic [1:0] sz; int cyc, st, off;
        for (int i = 0; i < 40; i++) begin
            rd   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 2));
            sx   = 1'($urandom_range(0, 1));
            off  = int'($urandom_range(0, DEPTH*4 + 15)) - 8;
            addr = BASE + off;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            data = $urandom;
            do_access(rd, !rd, sz, sx, addr, data, o, om, orr, cyc, st, da);
            model_access(!rd, sz, sx, addr, data, e, em, er);
            tests_run++; if (o !== e) begin tests_failed++; $display("FAIL rand_out[%0d]: addr=%0d got %h expected %h", i, addr, o, e); end
            tests_run++; if (om !== em || orr !== er) begin tests_failed++; $display("FAIL rand_err[%0d]: mis=%b rng=%b expected %b %b", i, om, orr, em, er); end
            tests_run++; if (cyc !== WS + 2 || st !== WS + 1) begin tests_failed++; $display("FAIL rand_timing[%0d]: cyc=%0d stall=%0d expected %0d %0d", i, cyc, st, WS + 2, WS + 1); end
        end
        test_full_readback();
    endtask

    task automatic test_reset_mid();
        logic [31:0] o, e; logic om, orr, em, er, da; int cyc, st;
        do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'd1032, 32'h0, o, om, orr, cyc, st, da);
        model_access(1'b0, 2'd2, 1'b0, 32'd1032, 32'h0, e, em, er);
        @(posedge clk); #1;
        w_en = 1'b1; r_en = 1'b0; size = 2'd2; alu_res = 32'd1040; st_value = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; w_en = 1'b0;
        @(posedge clk); #1;
        model_reset();
        tests_run++; if (stall !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ctrl: stall=%b done=%b expected 0 0", stall, done); end
        tests_run++; if (mem_out !== 32'h0 || mis !== 1'b0 || rng !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out: out=%h mis=%b rng=%b expected 0 0 0", mem_out, mis, rng); end
        @(posedge clk); #1;
        rst = 1'b1;
        do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'd1040, 32'h0, o, om, orr, cyc, st, da);
        model_access(1'b0, 2'd2, 1'b0, 32'd1040, 32'h0, e, em, er);
        tests_run++; if (o !== e) begin tests_failed++; $display("FAIL rst_mid_load: got %h expected %h", o, e); end
    endtask

    initial begin
        rst = 1'b0; r_en = 1'b0; w_en = 1'b0; size = 2'd0; sign_ext = 1'b0; alu_res = 32'h0; st_value = 32'h0;
        r1_en = 1'b0; w1_en = 1'b0; size1 = 2'd0; sx1 = 1'b0; a1 = 32'h0; d1 = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        test_word();
        test_byte();
        test_misalign();
        test_range();
        test_both_enables();
        test_wait0();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
